pipe_hazard_ctrl: RTL and testbench

Parametrised successor to the core's hazard detection logic. It centralises all pipeline stall and flush control for the N-stage RV32 pipeline: load-use hazards, taken branches, multi-cycle data-memory waits with timeout, and instruction-fetch waits. It owns the PC redirect, and keeps that redirect pending across fetch stalls. It sits beside the forwarding unit and drives every pipeline register's stall and flush inputs.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_perf.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default stage indices and performance counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1
  } hz_state_e;

  localparam int unsigned PC_IDX     = 0;
  localparam int unsigned IFID_IDX   = 1;
  localparam int unsigned IDEXE_IDX  = 2;
  localparam int unsigned EXEMEM_IDX = 3;
  localparam int unsigned MEMWB_IDX  = 4;

  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Free-running stall-cycle and flush-event counters; both wrap and clear on reset.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] flush_cnt_o
);

  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(PERF_CNT_W-1){1'b0}}, stall_i};
    flush_cnt_d = flush_cnt_q + {{(PERF_CNT_W-1){1'b0}}, flush_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect control for the N-stage pipeline.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 5,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned EXE_IDX     = IDEXE_IDX,
  parameter int unsigned MEM_IDX     = EXEMEM_IDX,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_hazard_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  input  logic                  imem_ready_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic                  mem_timeout_o,
  output logic [1:0]            state_o,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o
);

  localparam logic [NUM_STAGES-1:0] ONE        = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] DW_STALL_M = (ONE << (MEM_IDX + 1)) - ONE;
  localparam logic [NUM_STAGES-1:0] DW_FLUSH_M = ONE << (MEM_IDX + 1);
  localparam logic [NUM_STAGES-1:0] BR_FLUSH_M = (ONE << (EXE_IDX + 1)) - (ONE << 1);
  localparam logic [NUM_STAGES-1:0] LU_STALL_M = (ONE << EXE_IDX) - ONE;
  localparam logic [NUM_STAGES-1:0] LU_FLUSH_M = ONE << EXE_IDX;
  localparam logic [NUM_STAGES-1:0] FW_STALL_M = ONE << PC_IDX;
  localparam logic [NUM_STAGES-1:0] FW_FLUSH_M = ONE << IFID_IDX;

  hz_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  mto_q, mto_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

  logic                  tmo_hit, data_wait, branch_eff, load_eff, redirect;
  logic [NUM_STAGES-1:0] stall, flush;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  always_comb begin
    tmo_hit    = (MEM_TIMEOUT != 0) && (state_q == ST_DWAIT) &&
                 (cnt_q == CNT_WIDTH'(MEM_TIMEOUT));
    data_wait  = (state_q == ST_DWAIT) ? (!dmem_ack_i && !tmo_hit)
                                       : (dmem_req_i && !dmem_ack_i);
    branch_eff = branch_taken_i && !data_wait;
    load_eff   = load_hazard_i && !data_wait && !branch_taken_i;

    stall = '0;
    flush = '0;
    if (data_wait) begin
      stall = DW_STALL_M;
      flush = DW_FLUSH_M;
    end else begin
      if (branch_eff) begin
        flush = flush | BR_FLUSH_M;
      end else if (load_eff) begin
        stall = stall | LU_STALL_M;
        flush = flush | LU_FLUSH_M;
      end
      // IF/ID must hold (not bubble) while a load-use stall freezes it
      if (!imem_ready_i) begin
        stall = stall | FW_STALL_M;
        if (!load_eff) flush = flush | FW_FLUSH_M;
      end
    end

    redirect    = branch_eff || pend_q;
    redirect_pc = branch_eff ? branch_target_i : pend_pc_q;
    // Redirect is consumed only when the PC can actually load: fetch ready and not frozen
    pend_d      = redirect && !(imem_ready_i && !data_wait);
    pend_pc_d   = redirect_pc;

    state_d = state_q;
    cnt_d   = cnt_q;
    mto_d   = mto_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (dmem_req_i && !dmem_ack_i) state_d = ST_DWAIT;
      end
      ST_DWAIT: begin
        if (dmem_ack_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          mto_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    stall_o       = rst_i ? '0 : stall;
    flush_o       = rst_i ? '0 : flush;
    redirect_o    = rst_i ? 1'b0 : redirect;
    redirect_pc_o = rst_i ? '0 : redirect_pc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mto_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mto_q     <= mto_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign mem_timeout_o = mto_q;
  assign state_o       = state_q;

`ifdef HAZ_PERF_CNT_EN
  pipe_ctrl_perf u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_o[PC_IDX]),
    .flush_i     (|flush_o),
    .stall_cnt_o (perf_stall_cnt_o),
    .flush_cnt_o (perf_flush_cnt_o)
  );
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl (MEM_TIMEOUT=4 instance).
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic        rst, ld, br;
    logic [31:0] tgt;
    logic        req, ack, rdy;
    logic [4:0]  e_stall, e_flush;
    logic        e_redir, chk_pc;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_mto;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_hazard_i = 1'b0, branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        dmem_req_i = 1'b0, dmem_ack_i = 1'b0, imem_ready_i = 1'b1;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_o, mem_timeout_o;
  logic [31:0] redirect_pc_o, perf_stall_cnt_o, perf_flush_cnt_o;
  logic [1:0]  state_o;

  int unsigned n_tests = 0, n_fail = 0;
  logic [31:0] exp_ps = '0, exp_pf = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_hazard_i(load_hazard_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i), .imem_ready_i(imem_ready_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .mem_timeout_o(mem_timeout_o), .state_o(state_o),
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
  );

  function automatic vec_t mk(logic rst, logic ld, logic br, logic [31:0] tgt,
                              logic req, logic ack, logic rdy,
                              logic [4:0] st, logic [4:0] fl, logic rd,
                              logic cp, logic [31:0] pc, logic [1:0] s, logic m);
    vec_t v;
    v.rst = rst; v.ld = ld; v.br = br; v.tgt = tgt;
    v.req = req; v.ack = ack; v.rdy = rdy;
    v.e_stall = st; v.e_flush = fl; v.e_redir = rd;
    v.chk_pc = cp; v.e_pc = pc; v.e_st = s; v.e_mto = m;
    return v;
  endfunction

  task automatic chk32(string nm, int idx, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", nm, idx, got, want);
    end
  endtask

  // Drive one cycle, check mid-cycle, then advance to the next edge.
  task automatic apply(string nm, int idx, vec_t v);
    rst_i = v.rst; load_hazard_i = v.ld; branch_taken_i = v.br;
    branch_target_i = v.tgt; dmem_req_i = v.req; dmem_ack_i = v.ack;
    imem_ready_i = v.rdy;
    #3;
    chk32({nm, ".stall"}, idx, 32'(stall_o), 32'(v.e_stall));
    chk32({nm, ".flush"}, idx, 32'(flush_o), 32'(v.e_flush));
    chk32({nm, ".redirect"}, idx, 32'(redirect_o), 32'(v.e_redir));
    if (v.chk_pc) chk32({nm, ".redirect_pc"}, idx, redirect_pc_o, v.e_pc);
    chk32({nm, ".state"}, idx, 32'(state_o), 32'(v.e_st));
    chk32({nm, ".mem_timeout"}, idx, 32'(mem_timeout_o), 32'(v.e_mto));
    chk32({nm, ".perf_stall"}, idx, perf_stall_cnt_o, exp_ps);
    chk32({nm, ".perf_flush"}, idx, perf_flush_cnt_o, exp_pf);
`ifdef HAZ_PERF_CNT_EN
    if (v.rst) begin
      exp_ps = '0;
      exp_pf = '0;
    end else begin
      exp_ps = exp_ps + 32'(v.e_stall[0]);
      exp_pf = exp_pf + 32'(|v.e_flush);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t h[$];

  initial begin
    //           rst ld br tgt            req ack rdy  stall     flush     rd cp pc             st    mto
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 1, 32'h0,      2'd0, 0)); // reset values
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 0, 1, 5'b00011, 5'b00100, 0, 0, 32'h0,      2'd0, 0)); // load-use
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h100,    0, 0, 1, 5'b00000, 5'b00110, 1, 1, 32'h100,    2'd0, 0)); // branch
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 0)); // one-cycle redirect
    tbl.push_back(mk(0, 1, 1, 32'h140,    0, 0, 1, 5'b00000, 5'b00110, 1, 1, 32'h140,    2'd0, 0)); // branch beats load
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 0, 5'b00001, 5'b00010, 0, 0, 32'h0,      2'd0, 0)); // fetch wait
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 0, 0, 5'b00011, 5'b00100, 0, 0, 32'h0,      2'd0, 0)); // load + fetch wait
    tbl.push_back(mk(0, 0, 1, 32'h180,    0, 0, 0, 5'b00001, 5'b00110, 1, 1, 32'h180,    2'd0, 0)); // branch + fetch wait
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 0, 5'b00001, 5'b00010, 1, 1, 32'h180,    2'd0, 0)); // pending
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 1, 1, 32'h180,    2'd0, 0)); // consumed
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h1C0,    1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd0, 0)); // data wait entry
    tbl.push_back(mk(0, 1, 1, 32'h1C0,    1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h1C0,    1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h1C0,    1, 1, 1, 5'b00000, 5'b00110, 1, 1, 32'h1C0,    2'd1, 0)); // ack: branch honoured
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd0, 0)); // timeout run
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd1, 0)); // timeout release
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 1)); // sticky set
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 1, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 1)); // req+ack same cycle
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h100,    0, 0, 0, 5'b00001, 5'b00110, 1, 1, 32'h100,    2'd0, 1)); // redirect in fetch wait
    tbl.push_back(mk(0, 0, 1, 32'h200,    0, 0, 0, 5'b00001, 5'b00110, 1, 1, 32'h200,    2'd0, 1)); // younger wins
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 0, 5'b00001, 5'b00010, 1, 1, 32'h200,    2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 1, 1, 32'h200,    2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 1));

    // Reset mid-DWAIT: outputs and sticky flag clear, FSM back to RUN.
    h.push_back(mk(0, 0, 0, 32'h0,        1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd0, 1));
    h.push_back(mk(0, 0, 0, 32'h0,        1, 0, 1, 5'b01111, 5'b10000, 0, 0, 32'h0,      2'd1, 1));
    h.push_back(mk(1, 0, 0, 32'h0,        1, 0, 1, 5'b00000, 5'b00000, 0, 1, 32'h0,      2'd1, 1));
    h.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 5'b00000, 5'b00000, 0, 1, 32'h0,      2'd0, 0));
    // Pending redirect held across a data wait, released once unfrozen and fetch ready.
    h.push_back(mk(0, 0, 1, 32'h300,      0, 0, 0, 5'b00001, 5'b00110, 1, 1, 32'h300,    2'd0, 0));
    h.push_back(mk(0, 0, 0, 32'h0,        1, 0, 1, 5'b01111, 5'b10000, 1, 1, 32'h300,    2'd0, 0));
    h.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 5'b00000, 5'b00000, 1, 1, 32'h300,    2'd1, 0));
    h.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 5'b00000, 5'b00000, 0, 0, 32'h0,      2'd0, 0));

    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) apply("tbl", i, tbl[i]);
    foreach (h[i]) apply("seq", i, h[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
